// File: rtl/timer_pkg.sv
// Shared types and constants for the FF05..FF07 timer register block.
package timer_pkg;

  // TAC[1:0] divider tap selection
  typedef enum logic [1:0] {
    SEL_4096   = 2'b00,
    SEL_262144 = 2'b01,
    SEL_65536  = 2'b10,
    SEL_16384  = 2'b11
  } tac_sel_t;

  // Overflow sequencing states (only RUN is reachable without the delay option)
  typedef enum logic [1:0] {
    RUN    = 2'b00,
    OVF    = 2'b01,
    RELOAD = 2'b10
  } timer_state_t;

  // Register select {A1,A0}; 2'b00 is DIV and is served elsewhere
  localparam logic [1:0] SEL_TIMA = 2'b01;
  localparam logic [1:0] SEL_TMA  = 2'b10;
  localparam logic [1:0] SEL_TAC  = 2'b11;

  // TAC bits that read back as the constant filler
  localparam logic [7:0] TAC_READ_MASK = 8'hF8;

endpackage

// File: rtl/timer_tick_sel.sv
// Divider tap mux with enable gating and falling-edge tick detection.
module timer_tick_sel
  import timer_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] tac,
  input  logic       tap_4096,
  input  logic       tap_16384,
  input  logic       tap_65536,
  input  logic       tap_262144,
  output logic       tick_c
);

  logic mux_c;
  logic gated_c;
  logic tap_prev;

  // Select the divider tap named by TAC[1:0]
  always_comb begin
    mux_c = 1'b0;
    case (tac_sel_t'(tac[1:0]))
      SEL_4096:   mux_c = tap_4096;
      SEL_262144: mux_c = tap_262144;
      SEL_65536:  mux_c = tap_65536;
      SEL_16384:  mux_c = tap_16384;
      default:    mux_c = 1'b0;
    endcase
  end

  // Gating after the mux means disabling or reselecting while high yields a tick
  assign gated_c = mux_c & tac[2];

  // Remember last gated level for edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) tap_prev <= 1'b0;
    else     tap_prev <= gated_c;
  end

  assign tick_c = tap_prev & ~gated_c;

endmodule

// File: rtl/timer_regs.sv
// Timer registers TIMA/TMA/TAC with overflow reload and interrupt request.
// Option macro TIMER_OVF_DELAY_EN: one-cycle OVF then RELOAD sequencing;
// undefined, an overflow reloads TMA and raises the interrupt immediately.
module timer_regs
  import timer_pkg::*;
#(
  parameter logic [7:0] TIMA_RST   = 8'h00,
  parameter logic [4:0] TAC_UNUSED = 5'b11111
) (
  input  logic       boga1mhz,
  input  logic       reset,
  input  logic       ff04_ff07,
  input  logic       tola_na1,
  input  logic       tovy_na0,
  input  logic       cpu_wr,
  input  logic       cpu_rd,
  inout  wire  [7:0] d,
  input  logic       _4096hz,
  input  logic       _16384hz,
  input  logic       _65536hz,
  input  logic       _262144hz,
  output logic       int_timer,
  output logic [7:0] tima_q,
  output logic [7:0] tma_q,
  output logic [2:0] tac_q
);

  logic [1:0] sel_c;
  logic       wr_tima_c;
  logic       wr_tma_c;
  logic       wr_tac_c;
  logic       rd_en_c;
  logic [7:0] rdata_c;
  logic       tick_c;

  assign sel_c     = {tola_na1, tovy_na0};
  assign wr_tima_c = ff04_ff07 & cpu_wr & (sel_c == SEL_TIMA);
  assign wr_tma_c  = ff04_ff07 & cpu_wr & (sel_c == SEL_TMA);
  assign wr_tac_c  = ff04_ff07 & cpu_wr & (sel_c == SEL_TAC);
  assign rd_en_c   = ff04_ff07 & cpu_rd & (sel_c != 2'b00);

  // Read data mux; TAC upper bits return the filler constant
  always_comb begin
    rdata_c = 8'h00;
    case (sel_c)
      SEL_TIMA: rdata_c = tima_q;
      SEL_TMA:  rdata_c = tma_q;
      SEL_TAC:  rdata_c = (TAC_READ_MASK & {TAC_UNUSED, 3'b000}) | {5'b00000, tac_q};
      default:  rdata_c = 8'h00;
    endcase
  end

  assign d = rd_en_c ? rdata_c : 8'bzzzz_zzzz;

  timer_tick_sel u_tick_sel (
    .clk        (boga1mhz),
    .rst        (reset),
    .tac        (tac_q),
    .tap_4096   (_4096hz),
    .tap_16384  (_16384hz),
    .tap_65536  (_65536hz),
    .tap_262144 (_262144hz),
    .tick_c     (tick_c)
  );

  // TMA and TAC are plain write-only-from-bus registers
  always_ff @(posedge boga1mhz or posedge reset) begin
    if (reset) begin
      tma_q <= 8'h00;
      tac_q <= 3'b000;
    end else begin
      if (wr_tma_c) tma_q <= d;
      if (wr_tac_c) tac_q <= d[2:0];
    end
  end

`ifdef TIMER_OVF_DELAY_EN
  timer_state_t state;

  // TIMA counting with DMG overflow window: OVF reads 00, RELOAD loads TMA
  always_ff @(posedge boga1mhz or posedge reset) begin
    if (reset) begin
      tima_q    <= TIMA_RST;
      state     <= RUN;
      int_timer <= 1'b0;
    end else begin
      int_timer <= 1'b0;
      case (state)
        RUN: begin
          if (wr_tima_c) begin
            tima_q <= d;
          end else if (tick_c) begin
            if (tima_q == 8'hFF) begin
              tima_q <= 8'h00;
              state  <= OVF;
            end else begin
              tima_q <= tima_q + 8'd1;
            end
          end
        end
        OVF: begin
          if (wr_tima_c) begin
            tima_q <= d;
            state  <= RUN;
          end else begin
            tima_q    <= wr_tma_c ? d : tma_q;
            int_timer <= 1'b1;
            state     <= RELOAD;
          end
        end
        RELOAD: begin
          if (wr_tma_c)    tima_q <= d;
          else if (tick_c) tima_q <= tima_q + 8'd1;
          state <= RUN;
        end
        default: state <= RUN;
      endcase
    end
  end
`else
  // TIMA counting with immediate reload from TMA on overflow
  always_ff @(posedge boga1mhz or posedge reset) begin
    if (reset) begin
      tima_q    <= TIMA_RST;
      int_timer <= 1'b0;
    end else begin
      int_timer <= 1'b0;
      if (wr_tima_c) begin
        tima_q <= d;
      end else if (tick_c) begin
        if (tima_q == 8'hFF) begin
          tima_q    <= wr_tma_c ? d : tma_q;
          int_timer <= 1'b1;
        end else begin
          tima_q <= tima_q + 8'd1;
        end
      end
    end
  end
`endif

endmodule
